mar_mem_ctrl: RTL and testbench

Memory address register plus memory-access sequencer, directly downstream of the program counter. It captures the next address either from the PC (instruction fetch) or from the MBR's address field (operand access). It runs a single read or write transaction per start command against the memory via a req/ack handshake with timeout. Read data is returned to the MBR side with a one-cycle valid pulse.

---
 rtl/mar_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_mar_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mar_mem_ctrl.sv
// Memory address register and single-shot memory access sequencer.
// Loads MAR from PC or MBR, then runs one req/ack read or write.
module mar_mem_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc_mar,
  input  logic [ADDR_W-1:0] i_mbr_mar,
  input  logic              C2,
  input  logic              C8,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [ADDR_W-1:0] o_mar,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_valid,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: loads and starts only in IDLE, timeout in REQ
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (C2) begin
          mar_d = i_pc_mar;
        end else if (C8) begin
          mar_d = i_mbr_mar;
        end
        if (i_rd && i_wr) begin
          err_d = 1'b1;
        end else if (i_rd || i_wr) begin
          state_d = REQ;
          we_d    = i_wr;
          wdata_d = i_wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          if (!we_q) begin
            rdata_d = i_mem_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    o_mar         = mar_q;
    o_mem_addr    = mar_q;
    o_mem_wdata   = wdata_q;
    o_rdata       = rdata_q;
    o_err         = err_q;
    o_mem_req     = (state_q == REQ);
    o_mem_we      = (state_q == REQ) && we_q;
    o_done        = (state_q == DONE);
    o_rdata_valid = (state_q == DONE) && !we_q;
    o_busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mar_mem_ctrl.sv
// Directed bench for mar_mem_ctrl.
// Completions are checked against a queue of expected transactions.
module tb_mar_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc_mar, mbr_mar;
  logic        c2, c8, rd, wr;
  logic [15:0] wdata;
  logic [7:0]  mar, mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_rdata, rdata;
  logic        rdata_valid, done, busy, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          reqs;
  } exp_t;

  exp_t q[$];

  int          run = 0;
  int          last_run = 0;
  logic [7:0]  seen_addr;
  logic        seen_we;
  logic [15:0] seen_wdata;

  mar_mem_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc_mar      (pc_mar),
    .i_mbr_mar     (mbr_mar),
    .C2            (c2),
    .C8            (c8),
    .i_rd          (rd),
    .i_wr          (wr),
    .i_wdata       (wdata),
    .o_mar         (mar),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_rdata       (rdata),
    .o_rdata_valid (rdata_valid),
    .o_done        (done),
    .o_busy        (busy),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    c2 = 0; c8 = 0; rd = 0; wr = 0;
  endtask

  // Scoreboard monitor: track request runs, pop on each completion
  always @(negedge clk) begin
    if (mem_req) begin
      run++;
      seen_addr  = mem_addr;
      seen_we    = mem_we;
      seen_wdata = mem_wdata;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (done) begin
      chk("sb_pending", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_addr", 32'(seen_addr), 32'(e.addr));
        chk("sb_we", 32'(seen_we), 32'(e.we));
        chk("sb_reqs", 32'(last_run), 32'(e.reqs));
        chk("sb_valid", 32'(rdata_valid), 32'(!e.we));
        chk("sb_rdata", 32'(rdata), 32'(e.rdata));
        if (e.we) begin
          chk("sb_wdata", 32'(seen_wdata), 32'(e.wdata));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 0;
    idle_in();
    pc_mar = 0; mbr_mar = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #12;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mar", 32'(mar), 0);
    rst_n = 1;
    tick();

    // Fetch read: load from PC and start together, ack after 2 waits
    c2 = 1; pc_mar = 8'h05; rd = 1;
    q.push_back('{we: 0, addr: 8'h05, wdata: 16'h0,
                  rdata: 16'hA35C, reqs: 3});
    tick();
    idle_in();
    chk("rd_req1", 32'(mem_req), 1);
    chk("rd_we", 32'(mem_we), 0);
    chk("rd_addr", 32'(mem_addr), 32'h05);
    tick();
    chk("rd_req2", 32'(mem_req), 1);
    tick();
    chk("rd_req3", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 16'hA35C;
    tick();
    mem_ack = 0; mem_rdata = 16'h0;
    chk("rd_done", 32'(done), 1);
    chk("rd_valid", 32'(rdata_valid), 1);
    chk("rd_data", 32'(rdata), 32'hA35C);
    tick();
    chk("rd_done_pulse", 32'(done), 0);
    chk("rd_hold", 32'(rdata), 32'hA35C);

    // Operand write, zero-wait ack (ack held from IDLE is ignored)
    c8 = 1; mbr_mar = 8'h80; wr = 1; wdata = 16'h1234;
    mem_ack = 1; mem_rdata = 16'hFFFF;
    q.push_back('{we: 1, addr: 8'h80, wdata: 16'h1234,
                  rdata: 16'hA35C, reqs: 1});
    tick();
    idle_in();
    chk("wr_req", 32'(mem_req), 1);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_addr", 32'(mem_addr), 32'h80);
    tick();
    mem_ack = 0;
    chk("wr_done", 32'(done), 1);
    chk("wr_busy2", 32'(busy), 1);
    chk("wr_novalid", 32'(rdata_valid), 0);
    tick();
    chk("wr_idle", 32'(busy), 0);
    chk("wr_rdata", 32'(rdata), 32'hA35C);

    // Priority C2 over C8, then loads/starts blocked during REQ
    c2 = 1; c8 = 1; pc_mar = 8'h11; mbr_mar = 8'h22;
    tick();
    idle_in();
    chk("prio_mar", 32'(mar), 32'h11);
    rd = 1;
    q.push_back('{we: 0, addr: 8'h11, wdata: 16'h0,
                  rdata: 16'h5A5A, reqs: 2});
    tick();
    idle_in();
    c8 = 1; mbr_mar = 8'h33; rd = 1;
    tick();
    idle_in();
    chk("blk_mar", 32'(mar), 32'h11);
    chk("blk_err", 32'(err), 0);
    mem_ack = 1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 0;
    chk("blk_done", 32'(done), 1);
    tick();
    tick();
    chk("blk_mar2", 32'(mar), 32'h11);
    chk("blk_nosecond", 32'(busy), 0);

    // Timeout: no ack, req held exactly TIMEOUT cycles
    rd = 1;
    tick();
    idle_in();
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    chk("to_len", 32'(n), 15);
    chk("to_err", 32'(err), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_rdata", 32'(rdata), 32'h5A5A);

    // Next valid start clears the error
    rd = 1; mem_ack = 1; mem_rdata = 16'h0BEE;
    q.push_back('{we: 0, addr: 8'h11, wdata: 16'h0,
                  rdata: 16'h0BEE, reqs: 1});
    tick();
    idle_in();
    chk("clr_err", 32'(err), 0);
    tick();
    mem_ack = 0;
    chk("clr_done", 32'(done), 1);
    tick();

    // Read and write together: error, no request
    rd = 1; wr = 1;
    tick();
    idle_in();
    chk("both_err", 32'(err), 1);
    chk("both_req", 32'(mem_req), 0);
    chk("both_busy", 32'(busy), 0);
    tick();

    // Reset in the second REQ cycle, late ack must not complete
    rd = 1;
    tick();
    idle_in();
    tick();
    chk("mr_req2", 32'(mem_req), 1);
    rst_n = 0;
    #1;
    chk("mr_req_drop", 32'(mem_req), 0);
    chk("mr_busy", 32'(busy), 0);
    #2;
    rst_n = 1;
    mem_ack = 1;
    tick();
    tick();
    mem_ack = 0;
    chk("mr_nodone", 32'(done), 0);
    chk("mr_idle", 32'(busy), 0);

    // Random inputs with reset asserted mid-simulation
    c2 = 1'($urandom); c8 = 1'($urandom);
    rd = 1'($urandom); wr = 1'($urandom);
    pc_mar = 8'($urandom); mbr_mar = 8'($urandom);
    wdata = 16'($urandom); mem_rdata = 16'($urandom);
    mem_ack = 1'($urandom);
    rst_n = 0;
    #1;
    chk("rr_mar", 32'(mar), 0);
    chk("rr_addr", 32'(mem_addr), 0);
    chk("rr_wdata", 32'(mem_wdata), 0);
    chk("rr_rdata", 32'(rdata), 0);
    chk("rr_flags", 32'({mem_req, mem_we, rdata_valid, done, busy, err}), 0);
    tick();
    idle_in();
    mem_ack = 0;
    #2;
    rst_n = 1;
    tick();
    chk("rr_busy", 32'(busy), 0);

    chk("sb_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
